// File: rtl/fir_tap_mac.sv
// Four-tap signed Q1.7 multiply-accumulate core for the FIR filter.
// Taps are accumulated serially. The result is rounded, saturated to Q3.7 and flagged with a one-cycle done pulse.
module fir_tap_mac (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mac_enable,
  input  logic [7:0] h_0,
  input  logic [7:0] h_1,
  input  logic [7:0] h_2,
  input  logic [7:0] h_3,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic [7:0] data_3,
  output logic [9:0] data_out,
  output logic       mac_done
);

  typedef enum logic [1:0] {IDLE, ACC, FIN, HOLD} state_e;

  state_e             state_q, state_d;
  logic signed [17:0] acc_q, acc_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0][7:0]    h_q, h_d;
  logic [3:0][7:0]    x_q, x_d;
  logic [9:0]         data_out_q, data_out_d;
  logic               mac_done_q, mac_done_d;

  logic signed [15:0] h_ext, x_ext, prod;
  logic signed [17:0] prod_ext;
  logic signed [18:0] rnd;
  logic signed [11:0] shifted;
  logic [9:0]         sat;

  always_comb begin
    h_ext    = {{8{h_q[idx_q][7]}}, h_q[idx_q]};
    x_ext    = {{8{x_q[idx_q][7]}}, x_q[idx_q]};
    prod     = h_ext * x_ext;
    prod_ext = {{2{prod[15]}}, prod};
    // Round half up, then take bits [18:7] as the arithmetic shift right by 7.
    rnd      = {acc_q[17], acc_q} + 19'sd64;
    shifted  = rnd[18:7];
    if (shifted > 12'sd511) begin
      sat = 10'h1FF;
    end else if (shifted < -12'sd512) begin
      sat = 10'h200;
    end else begin
      sat = shifted[9:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    h_d        = h_q;
    x_d        = x_q;
    data_out_d = data_out_q;
    mac_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mac_enable) begin
          h_d     = {h_3, h_2, h_1, h_0};
          x_d     = {data_3, data_2, data_1, data_0};
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = FIN;
        end
      end
      FIN: begin
        data_out_d = sat;
        mac_done_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (!mac_enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      h_q        <= '0;
      x_q        <= '0;
      data_out_q <= '0;
      mac_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      h_q        <= h_d;
      x_q        <= x_d;
      data_out_q <= data_out_d;
      mac_done_q <= mac_done_d;
    end
  end

  assign data_out = data_out_q;
  assign mac_done = mac_done_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Self-checking bench for fir_tap_mac. It uses directed and randomized operations.
// Results are checked against a real-valued model of the dot product.
module tb_fir_tap_mac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mac_enable;
  logic [7:0] h_0, h_1, h_2, h_3;
  logic [7:0] data_0, data_1, data_2, data_3;
  logic [9:0] data_out;
  logic       mac_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_tap_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mac_enable(mac_enable),
    .h_0       (h_0),
    .h_1       (h_1),
    .h_2       (h_2),
    .h_3       (h_3),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .data_3    (data_3),
    .data_out  (data_out),
    .mac_done  (mac_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Dot product in real numbers, scaled to Q3.7, rounded half up, clamped.
  function automatic int ref_result(input logic [3:0][7:0] h, input logic [3:0][7:0] d);
    real s;
    real q;
    s = 0.0;
    for (int i = 0; i < 4; i++) begin
      s = s + (real'($signed(h[i])) / 128.0) * (real'($signed(d[i])) / 128.0);
    end
    q = $floor(s * 128.0 + 0.5);
    if (q > 511.0) q = 511.0;
    if (q < -512.0) q = -512.0;
    return $rtoi(q);
  endfunction

  function automatic int dout_s();
    return int'($signed(data_out));
  endfunction

  task automatic drive_ops(input logic [3:0][7:0] h, input logic [3:0][7:0] d);
    h_0 = h[0]; h_1 = h[1]; h_2 = h[2]; h_3 = h[3];
    data_0 = d[0]; data_1 = d[1]; data_2 = d[2]; data_3 = d[3];
  endtask

  // Entered and left at posedge+1. hold = extra enabled cycles after done; low = edges with enable low.
  task automatic do_op(input string tag, input logic [3:0][7:0] h, input logic [3:0][7:0] d,
                       input int hold, input int low, input bit drop_early, output int result);
    int exp;
    int lat;
    int pulses;
    exp    = ref_result(h, d);
    lat    = -1;
    pulses = 0;
    drive_ops(h, d);
    mac_enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (mac_done) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (k == 0) begin
        drive_ops({$urandom(), $urandom()}, {$urandom(), $urandom()});
        if (drop_early) mac_enable = 1'b0;
      end
      if (lat >= 0) break;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_data_out"}, dout_s(), exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (mac_done) pulses++;
    end
    mac_enable = 1'b0;
    for (int k = 0; k < low; k++) begin
      @(posedge clk); #1;
      if (mac_done) pulses++;
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_held"}, dout_s(), exp);
    result = dout_s();
  endtask

  initial begin
    int r;
    int pulses;
    logic [3:0][7:0] rh, rd;

    rst_n      = 1'b1;
    mac_enable = 1'b0;
    drive_ops('0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", dout_s(), 0);
    check("reset_done", int'(mac_done), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    do_op("tp_mix", {8'hC0, 8'h40, 8'h40, 8'h40}, {8'hC0, 8'h40, 8'h40, 8'h20}, 0, 3, 1'b0, r);
    check("tp_mix_const", r, 112);
    do_op("tp_sat_pos", {4{8'h80}}, {4{8'h80}}, 0, 1, 1'b0, r);
    check("tp_sat_pos_const", r, 511);
    do_op("tp_neg", {4{8'h80}}, {4{8'h7F}}, 0, 1, 1'b0, r);
    check("tp_neg_const", r, -508);
    do_op("tp_rnd_half", {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h40}, 0, 1, 1'b0, r);
    check("tp_rnd_half_const", r, 1);
    do_op("tp_rnd_neg", {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'h40}, 0, 1, 1'b0, r);
    check("tp_rnd_neg_const", r, 0);
    do_op("tp_hold20", {8'h10, 8'h20, 8'h30, 8'h40}, {8'h7F, 8'h81, 8'h40, 8'h20}, 20, 1, 1'b0, r);
    do_op("tp_restart", {8'hF0, 8'h7F, 8'h01, 8'h80}, {8'h33, 8'h80, 8'h7F, 8'h05}, 0, 1, 1'b0, r);
    do_op("tp_drop_acc", {8'h55, 8'hAA, 8'h12, 8'hEE}, {8'h66, 8'h99, 8'h7F, 8'h80}, 2, 1, 1'b1, r);

    // Reset during accumulation: no done pulse and data_out cleared.
    drive_ops({8'h40, 8'h40, 8'h40, 8'h40}, {8'h40, 8'h40, 8'h40, 8'h40});
    mac_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n      = 1'b1;
    mac_enable = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (mac_done) pulses++;
    end
    check("rst_acc_pulses", pulses, 0);
    check("rst_acc_data_out", dout_s(), 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0:       rh[i] = 8'h80;
          1:       rh[i] = 8'h7F;
          default: rh[i] = 8'($urandom());
        endcase
        case ($urandom_range(0, 5))
          0:       rd[i] = 8'h80;
          1:       rd[i] = 8'h7F;
          default: rd[i] = 8'($urandom());
        endcase
      end
      do_op($sformatf("rand%0d", n), rh, rd, $urandom_range(0, 3), $urandom_range(1, 2),
            1'($urandom_range(0, 1)), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
